lr3_ce_sched: RTL and testbench

LR3_CE_SCHED -- requirements
Module: lr3_ce_sched

---
 rtl/lr3_ce_sched.sv | 113 +++++++++++
 tb/tb_lr3_ce_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lr3_ce_sched.sv
// lr3_ce_sched: N_CH programmable clock-enable dividers, round-robin pulse arbiter.
// Ports: CLK/RST, CFG_WE/CFG_CH/CFG_DIV/CFG_RDY config write, CLR_OVR, CE pulses, OVR flags.
module lr3_ce_sched #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CFG_WE,
  input  logic [CH_W-1:0]  CFG_CH,
  input  logic [DIV_W-1:0] CFG_DIV,
  output logic             CFG_RDY,
  input  logic [N_CH-1:0]  CLR_OVR,
  output logic [N_CH-1:0]  CE,
  output logic [N_CH-1:0]  OVR
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]       state_q;
  logic [DIV_W-1:0] div_q [N_CH];
  logic [DIV_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  ovr_q;
  logic [N_CH-1:0]  ce_q;
  logic [CH_W-1:0]  ptr_q;

  logic             accept;
  logic [N_CH-1:0]  term;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  gnt_oh;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_vld;
  int               j;

  assign accept  = (state_q == S_IDLE) && CFG_WE;
  assign CFG_RDY = (state_q == S_IDLE);
  assign CE      = ce_q;
  assign OVR     = ovr_q;

  always_comb begin
    term   = '0;
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      term[i]   = (div_q[i] != '0) &&
                  (cnt_q[i] == div_q[i] - DIV_W'(1));
      wr_hit[i] = accept && (CFG_CH == CH_W'(i));
    end
  end

  // Round-robin: scan starting one past the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    gnt_oh  = '0;
    j       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      j = (int'(ptr_q) + k) % N_CH;
      if (!gnt_vld && pend_q[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(j);
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (CFG_WE) state_q <= S_LOAD;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
      ovr_q  <= '0;
      ce_q   <= '0;
      ptr_q  <= CH_W'(N_CH - 1);
    end else begin
      ce_q <= gnt_oh;
      if (gnt_vld) ptr_q <= gnt_idx;
      for (int i = 0; i < N_CH; i++) begin
        if (wr_hit[i]) begin
          div_q[i] <= CFG_DIV;
          cnt_q[i] <= '0;
        end else if (div_q[i] == '0 || term[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        end
        // A new event on a granted channel re-arms it instead of overrunning.
        if (wr_hit[i])      pend_q[i] <= 1'b0;
        else if (term[i])   pend_q[i] <= 1'b1;
        else if (gnt_oh[i]) pend_q[i] <= 1'b0;
        // Overrun set takes priority over the clear.
        if (term[i] && pend_q[i] && !gnt_oh[i]) ovr_q[i] <= 1'b1;
        else if (CLR_OVR[i])                    ovr_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lr3_ce_sched.sv
// tb_lr3_ce_sched: random and directed stimulus for lr3_ce_sched
// against an event-time model of the divider/arbiter behaviour.
module tb_lr3_ce_sched;
  localparam int N = 4;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CFG_WE = 1'b0;
  logic [1:0]   CFG_CH = '0;
  logic [W-1:0] CFG_DIV = '0;
  logic         CFG_RDY;
  logic [N-1:0] CLR_OVR = '0;
  logic [N-1:0] CE;
  logic [N-1:0] OVR;

  lr3_ce_sched #(.N_CH(N), .DIV_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_DIV(CFG_DIV),
    .CFG_RDY(CFG_RDY), .CLR_OVR(CLR_OVR),
    .CE(CE), .OVR(OVR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  longint       t;
  int           m_div [N];
  longint       m_start [N];
  logic [N-1:0] m_pend, m_ovr, m_ce;
  int           m_ptr;
  bit           m_busy;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
  endtask

  function automatic bit m_event(input int i);
    if (m_div[i] == 0) return 1'b0;
    return ((t - m_start[i]) % m_div[i]) == longint'(m_div[i] - 1);
  endfunction

  task automatic m_reset();
    t = 0;
    for (int i = 0; i < N; i++) begin
      m_div[i] = 0;
      m_start[i] = 0;
    end
    m_pend = '0;
    m_ovr = '0;
    m_ce = '0;
    m_ptr = N - 1;
    m_busy = 0;
  endtask

  task automatic m_step(input bit we, input int ch, input int d,
                        input logic [N-1:0] clr);
    logic [N-1:0] ev;
    int g;
    g = -1;
    for (int i = 0; i < N; i++) ev[i] = m_event(i);
    for (int k = 1; k <= N; k++) begin
      int jj;
      jj = (m_ptr + k) % N;
      if (g < 0 && m_pend[jj]) g = jj;
    end
    m_ce = '0;
    if (g >= 0) begin
      m_ce[g] = 1'b1;
      m_ptr = g;
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i] && m_pend[i] && g != i) m_ovr[i] = 1'b1;
      else if (clr[i]) m_ovr[i] = 1'b0;
      if (we && !m_busy && ch == i) m_pend[i] = 1'b0;
      else if (ev[i]) m_pend[i] = 1'b1;
      else if (g == i) m_pend[i] = 1'b0;
    end
    if (we && !m_busy && ch < N) begin
      m_div[ch] = d;
      m_start[ch] = t + 1;
    end
    m_busy = we && !m_busy;
    t++;
  endtask

  task automatic compare();
    chk("ce", CE, m_ce);
    chk("ovr", OVR, m_ovr);
    chk("rdy", CFG_RDY, !m_busy);
  endtask

  task automatic step(input bit we, input int ch, input int d,
                      input logic [N-1:0] clr);
    CFG_WE = we;
    CFG_CH = ch[1:0];
    CFG_DIV = d[W-1:0];
    CLR_OVR = clr;
    m_step(we, ch, d, clr);
    @(negedge CLK);
    compare();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, '0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CFG_WE = 1'b0;
    CLR_OVR = '0;
    #1;
    chk("rst_ce", CE, 0);
    chk("rst_ovr", OVR, 0);
    chk("rst_rdy", CFG_RDY, 1);
    m_reset();
    @(negedge CLK);
    RST = 1'b0;
    compare();
  endtask

  task automatic wait_ce(input logic [N-1:0] pat, input string nm);
    int k;
    k = 0;
    while (CE !== pat && k < 16) begin
      step(0, 0, 0, '0);
      k++;
    end
    chk(nm, CE, pat);
  endtask

  task automatic mid_reset();
    logic [N-1:0] acc;
    CFG_WE = 1'b0;
    CLR_OVR = '0;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_ce", CE, 0);
    chk("mid_rst_ovr", OVR, 0);
    chk("mid_rst_rdy", CFG_RDY, 1);
    m_reset();
    @(negedge CLK);
    RST = 1'b0;
    compare();
    acc = '0;
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, '0);
      acc = acc | CE;
    end
    chk("post_rst_no_ce", acc, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [12:0]  h;
    logic [5:0]   r;
    logic [N-1:0] acc;
    @(negedge CLK);
    do_reset();
    idle(10);

    // single channel, DIV=5
    step(1, 0, 5, '0);
    chk("t1_rdy_low", CFG_RDY, 0);
    h = '0;
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, '0);
      h[k] = CE[0];
      if (k == 1) chk("t1_rdy_back", CFG_RDY, 1);
    end
    chk("t1_ce0_hist", h, 13'h0840);
    chk("t1_ovr", OVR, 0);

    // round robin, coincident DIV=4 events
    do_reset();
    step(1, 0, 4, '0); idle(3);
    step(1, 1, 4, '0); idle(3);
    step(1, 2, 4, '0); idle(3);
    step(1, 3, 4, '0);
    idle(8);
    wait_ce(4'b0001, "t2_ce0");
    step(0, 0, 0, '0); chk("t2_ce1", CE, 4'b0010);
    step(0, 0, 0, '0); chk("t2_ce2", CE, 4'b0100);
    step(0, 0, 0, '0); chk("t2_ce3", CE, 4'b1000);
    chk("t2_ovr", OVR, 0);

    // disable ch1 while it is pending
    step(1, 1, 0, '0);
    acc = '0;
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, '0);
      acc = acc | CE;
    end
    chk("t3_no_ce1", acc[1], 0);
    chk("t3_others", acc, 4'b1101);
    r = '0;
    for (int k = 0; k < 6; k++) begin
      step(1, 2, 4, '0);
      r[k] = CFG_RDY;
    end
    chk("t3_we_held_rdy", r, 6'h2A);
    idle(2);

    // overrun, all DIV=1
    do_reset();
    step(1, 0, 1, '0); idle(1);
    step(1, 1, 1, '0); idle(1);
    step(1, 2, 1, '0); idle(1);
    step(1, 3, 1, '0);
    idle(8);
    chk("t4_ovr_all", OVR, 4'hF);
    wait_ce(4'b0001, "t4_ce0");
    step(0, 0, 0, '0); chk("t4_ce1", CE, 4'b0010);
    step(0, 0, 0, '0); chk("t4_ce2", CE, 4'b0100);
    step(0, 0, 0, '0); chk("t4_ce3", CE, 4'b1000);

    // clear colliding with overrun, then clear on disabled channel
    step(0, 0, 0, '0);
    step(0, 0, 0, 4'b0001);
    chk("t5_ovr0_keep", OVR[0], 1);
    step(1, 0, 0, '0);
    idle(4);
    step(0, 0, 0, 4'b0001);
    chk("t5_ovr0_clr", OVR[0], 0);
    chk("t5_ovr_rest", OVR[3:1], 3'b111);

    // randomized run with mid-run resets
    do_reset();
    for (int blk = 0; blk < 3; blk++) begin
      for (int k = 0; k < 200; k++) begin
        int d;
        logic [N-1:0] c;
        d = ($urandom_range(0, 9) == 9) ? int'($urandom_range(0, 65535))
                                        : int'($urandom_range(0, 6));
        c = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
        step($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), d, c);
      end
      mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
